// File: rtl/exotiny_uart_pkg.sv
// Shared constants and types for the exotiny console UART transmitter.
package exotiny_uart_pkg;

  localparam logic [4:0] ADR_TXDATA = 5'h0C;
  localparam logic [4:0] ADR_STATUS = 5'h10;
  localparam logic [4:0] ADR_BAUD   = 5'h14;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_DONE  = 3;
  localparam int ST_ERR   = 4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam logic [31:0] PAT_DONE = 32'h444F4E45; // "DONE"
  localparam logic [23:0] PAT_ERR  = 24'h455252;   // "ERR"

endpackage

// File: rtl/exotiny_uart_fifo.sv
// Small synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module exotiny_uart_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + ONE;
    end
  end

endmodule

// File: rtl/exotiny_uart_tx.sv
// Console UART on the regs bus: byte FIFO, 8N1 serializer and DONE/ERR string detector.
module exotiny_uart_tx
  import exotiny_uart_pkg::*;
#(
  parameter int               FIFO_DEPTH = 4,
  parameter int               DIV_W      = 16,
  parameter logic [DIV_W-1:0] DIV_RST    = 16'd104
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        tx_o,
  output logic        done_o,
  output logic        err_o
);

  logic [2:0]       reg_sel;
  logic             is_tx, hold, accept, push, pop;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;
  logic [DIV_W-1:0] div, div_lat, cnt;
  logic [31:0]      hist, hist_nxt, status, rd_val;
  tx_state_t        state;
  logic [7:0]       shreg;
  logic [2:0]       bit_idx;
  logic             bit_end;
  logic             unused_bits;

  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i};

  assign reg_sel = wb_adr_i[4:2];
  assign is_tx   = (reg_sel == ADR_TXDATA[4:2]);
  // A TXDATA write into a full FIFO is held off the bus until a slot frees.
  assign hold    = wb_we_i && is_tx && fifo_full;
  assign accept  = wb_stb_i && !wb_ack_o && !hold;
  assign push    = accept && wb_we_i && is_tx;
  assign pop     = (state == IDLE) && !fifo_empty;
  assign hist_nxt = {hist[23:0], wb_dat_i[7:0]};

  exotiny_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .din   (wb_dat_i[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    status           = '0;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_BUSY]  = (state != IDLE) || !fifo_empty;
    status[ST_DONE]  = done_o;
    status[ST_ERR]   = err_o;
  end

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      ADR_STATUS[4:2]: rd_val = status;
      ADR_BAUD[4:2]:   rd_val[DIV_W-1:0] = div;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      div      <= DIV_RST;
      hist     <= '0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      wb_ack_o <= accept;
      wb_dat_o <= (accept && !wb_we_i) ? rd_val : '0;
      if (accept && wb_we_i && reg_sel == ADR_BAUD[4:2])
        div <= (wb_dat_i[DIV_W-1:0] == '0) ? DIV_W'(1) : wb_dat_i[DIV_W-1:0];
      // Flags follow the post-push history so they rise together with the ack.
      if (push) begin
        hist <= hist_nxt;
        if (hist_nxt == PAT_DONE)       done_o <= 1'b1;
        if (hist_nxt[23:0] == PAT_ERR)  err_o  <= 1'b1;
      end
    end
  end

  assign bit_end = (cnt == div_lat - DIV_W'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      tx_o    <= 1'b1;
      shreg   <= '0;
      bit_idx <= '0;
      cnt     <= '0;
      div_lat <= DIV_RST;
    end else begin
      case (state)
        IDLE: begin
          tx_o <= 1'b1;
          if (!fifo_empty) begin
            shreg   <= fifo_dout;
            div_lat <= div;
            cnt     <= '0;
            bit_idx <= '0;
            tx_o    <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt   <= '0;
            tx_o  <= shreg[0];
            state <= DATA;
          end else cnt <= cnt + DIV_W'(1);
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_o  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx_o    <= shreg[1];
            end
          end else cnt <= cnt + DIV_W'(1);
        end
        STOP: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= IDLE;
          end else cnt <= cnt + DIV_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exotiny_uart_tx.sv
// Randomized bench for exotiny_uart_tx: serial trace compared to an 8N1 frame model.
module tb_exotiny_uart_tx;
  import exotiny_uart_pkg::*;

  localparam int TMAX = 8192;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [4:0]  wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, tx_o, done_o, err_o;

  int   n_tests = 0, n_fail = 0;
  int   cyc = 0;
  logic trace [TMAX];

  logic [31:0] m_hist;
  logic        m_done, m_err;
  logic [31:0] pat_done = "DONE";
  logic [23:0] pat_err  = "ERR";

  always #5 clk = ~clk;

  exotiny_uart_tx #(.FIFO_DEPTH(4), .DIV_W(16), .DIV_RST(16'd4)) dut (
    .clk_i(clk), .rst_i(rst_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .tx_o(tx_o), .done_o(done_o), .err_o(err_o)
  );

  always @(negedge clk) begin
    if (cyc < TMAX) trace[cyc] = tx_o;
    cyc = cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_hist = '0; m_done = 1'b0; m_err = 1'b0;
  endtask

  task automatic xfer(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                      output logic [31:0] rdat, output int lat);
    @(posedge clk); #1;
    wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!wb_ack_o && lat < 300);
    if (!wb_ack_o) chk("ack_timeout", {31'd0, wb_ack_o}, 32'd1);
    rdat = wb_dat_o;
    wb_stb_i = 1'b0; wb_we_i = 1'b0;
    if (we && adr == ADR_TXDATA && wb_ack_o) begin
      m_hist = {m_hist[23:0], dat[7:0]};
      if (m_hist == pat_done) m_done = 1'b1;
      if (m_hist[23:0] == pat_err) m_err = 1'b1;
      chk("done_flag", {31'd0, done_o}, {31'd0, m_done});
      chk("err_flag", {31'd0, err_o}, {31'd0, m_err});
    end
  endtask

  task automatic wr(input logic [4:0] adr, input logic [31:0] dat, output int lat);
    logic [31:0] d;
    xfer(1'b1, adr, dat, d, lat);
  endtask

  task automatic rd(input logic [4:0] adr, output logic [31:0] dat, output int lat);
    xfer(1'b0, adr, 32'h0, dat, lat);
  endtask

  task automatic find_start(input int from, output int s);
    s = -1;
    for (int i = from; i < cyc && i < TMAX; i++)
      if (trace[i] === 1'b0) begin s = i; break; end
  endtask

  // Expected frame: one low start bit, 8 data bits LSB first, one high stop bit, d samples each.
  task automatic check_frame(input string tag, input int s, input int d, input logic [7:0] b);
    int bad;
    logic e;
    bad = 0;
    if (s < 0 || s + 10*d + 1 > cyc) bad = 1000;
    else begin
      for (int k = 0; k < 10; k++) begin
        e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
        for (int j = 0; j < d; j++)
          if (trace[s + k*d + j] !== e) bad++;
      end
      if (trace[s + 10*d] !== 1'b1) bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  bq [6];
    int lat, s, prev, base;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, tx_o}, 32'd1);
    chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    rst_i = 1'b0;

    rd(ADR_STATUS, d, lat);
    chk("rst_status", d, 32'h1);
    rd(ADR_BAUD, d, lat);
    chk("rst_baud", d, 32'd4);
    rd(5'h00, d, lat);
    chk("unmapped_rd", d, 32'd0);
    chk("unmapped_lat", lat, 1);
    rd(ADR_TXDATA, d, lat);
    chk("txdata_rd", d, 32'd0);
    wr(ADR_STATUS, 32'hFFFF_FFFF, lat);
    rd(ADR_STATUS, d, lat);
    chk("status_wr_ignored", d, 32'h1);

    // Single frame at divisor 4
    base = cyc;
    wr(ADR_TXDATA, 32'h41, lat);
    chk("tx_ack_lat", lat, 1);
    repeat (50) @(posedge clk);
    find_start(base, s);
    check_frame("frame_41", s, 4, 8'h41);

    // Divisor 0 is stored as 1; a mid-frame change only affects the next frame
    wr(ADR_BAUD, 32'h0, lat);
    rd(ADR_BAUD, d, lat);
    chk("baud_zero", d, 32'd1);
    wr(ADR_BAUD, 32'd4, lat);
    bq[0] = 8'($urandom_range(0, 255));
    bq[1] = 8'($urandom_range(0, 255));
    base = cyc;
    wr(ADR_TXDATA, {24'd0, bq[0]}, lat);
    repeat (5) @(posedge clk);
    wr(ADR_BAUD, 32'd2, lat);
    wr(ADR_TXDATA, {24'd0, bq[1]}, lat);
    repeat (80) @(posedge clk);
    find_start(base, s);
    check_frame("frame_oldbaud", s, 4, bq[0]);
    prev = s;
    find_start(prev + 40, s);
    chk("gap_baud", s - prev, 41);
    check_frame("frame_newbaud", s, 2, bq[1]);

    // FIFO overflow: sixth write stalls until the first frame pops a slot
    wr(ADR_BAUD, 32'd4, lat);
    base = cyc;
    for (int i = 0; i < 5; i++) begin
      bq[i] = 8'($urandom_range(128, 255));
      wr(ADR_TXDATA, {24'd0, bq[i]}, lat);
      chk("push_lat", lat, 1);
    end
    rd(ADR_STATUS, d, lat);
    chk("status_full", d, 32'h06);
    bq[5] = 8'($urandom_range(128, 255));
    wr(ADR_TXDATA, {24'd0, bq[5]}, lat);
    chk("stall_seen", {31'd0, lat > 10}, 32'd1);
    repeat (300) @(posedge clk);
    find_start(base, s);
    check_frame("ovf_frame0", s, 4, bq[0]);
    for (int i = 1; i < 6; i++) begin
      prev = s;
      find_start(prev + 40, s);
      chk("ovf_gap", s - prev, 41);
      check_frame("ovf_frame", s, 4, bq[i]);
    end
    rd(ADR_STATUS, d, lat);
    chk("status_drained", d, 32'h1);

    // End-of-test string "xDONE"
    wr(ADR_TXDATA, 32'h78, lat);
    wr(ADR_TXDATA, 32'h44, lat);
    wr(ADR_TXDATA, 32'h4F, lat);
    wr(ADR_TXDATA, 32'h4E, lat);
    chk("done_before_E", {31'd0, done_o}, 32'd0);
    wr(ADR_TXDATA, 32'h45, lat);
    chk("done_at_ack", {31'd0, done_o}, 32'd1);
    rd(ADR_STATUS, d, lat);
    chk("status_done", d & 32'h19, 32'h08);
    chk("status_busy", {31'd0, d[ST_BUSY]}, 32'd1);
    wr(ADR_TXDATA, 32'h5A, lat);
    chk("done_sticky", {31'd0, done_o}, 32'd1);

    // "ERR" after a fresh reset
    do_reset();
    wr(ADR_TXDATA, 32'h45, lat);
    wr(ADR_TXDATA, 32'h52, lat);
    chk("err_before_R", {31'd0, err_o}, 32'd0);
    wr(ADR_TXDATA, 32'h52, lat);
    chk("err_set", {31'd0, err_o}, 32'd1);
    chk("err_no_done", {31'd0, done_o}, 32'd0);
    do_reset();
    chk("rst2_err", {31'd0, err_o}, 32'd0);
    chk("rst2_done", {31'd0, done_o}, 32'd0);
    chk("rst2_tx", {31'd0, tx_o}, 32'd1);
    rd(ADR_STATUS, d, lat);
    chk("rst2_status", d, 32'h1);

    // Reset during the data bits of 0x55 with two bytes still queued
    repeat (50) @(posedge clk);
    wr(ADR_TXDATA, 32'h55, lat);
    wr(ADR_TXDATA, 32'hA3, lat);
    wr(ADR_TXDATA, 32'h3A, lat);
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_tx", {31'd0, tx_o}, 32'd0);
    rst_i = 1'b1;
    @(posedge clk); #1;
    chk("midframe_rst_tx", {31'd0, tx_o}, 32'd1);
    rst_i = 1'b0;
    model_reset();
    base = cyc;
    repeat (150) @(posedge clk);
    find_start(base, s);
    chk("no_frame_after_rst", s, -1);
    rd(ADR_STATUS, d, lat);
    chk("status_after_rst", d, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
